// File: rtl/vga_rect_compositor_if.sv
// Descriptor write / commit port of vga_rect_compositor.
// wr_border exists only when VGA_RECT_BORDER_EN is defined.
interface vga_rect_compositor_if #(
  parameter int IDX_W   = 2,
  parameter int COLOR_W = 4
);
  logic                   wr_valid;
  logic                   wr_ready;
  logic [IDX_W-1:0]       wr_idx;
  logic [10:0]            wr_x0;
  logic [10:0]            wr_x1;
  logic [9:0]             wr_y0;
  logic [9:0]             wr_y1;
  logic [3*COLOR_W-1:0]   wr_color;
  logic                   wr_en;
`ifdef VGA_RECT_BORDER_EN
  logic                   wr_border;
`endif
  logic                   commit;
  logic                   commit_pending;

  modport master (
`ifdef VGA_RECT_BORDER_EN
    output wr_border,
`endif
    output wr_valid, wr_idx, wr_x0, wr_x1, wr_y0, wr_y1, wr_color, wr_en, commit,
    input  wr_ready, commit_pending
  );

  modport slave (
`ifdef VGA_RECT_BORDER_EN
    input  wr_border,
`endif
    input  wr_valid, wr_idx, wr_x0, wr_x1, wr_y0, wr_y1, wr_color, wr_en, commit,
    output wr_ready, commit_pending
  );
endinterface

// File: rtl/vga_rect_compositor.sv
// SVGA compositor of NUM_RECTS prioritised rectangles with frame-synchronous shadow commit.
// Define VGA_RECT_BORDER_EN to add per-slot outline-only mode (wr_border).
module vga_rect_compositor #(
  parameter int          NUM_RECTS = 4,
  parameter int          COLOR_W   = 4,
  parameter logic [15:0] STB_INC   = 16'h6666,
  parameter int          H_ACTIVE  = 800,
  parameter int          H_FP      = 40,
  parameter int          H_SYNC    = 128,
  parameter int          H_BP      = 88,
  parameter int          V_ACTIVE  = 600,
  parameter int          V_FP      = 1,
  parameter int          V_SYNC    = 4,
  parameter int          V_BP      = 23,
  parameter int          IDX_W     = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1
) (
  input  logic                 CLK,
  input  logic                 RST_BTN,
  vga_rect_compositor_if.slave wr,
  output logic                 frame_start,
  output logic                 VGA_HS_O,
  output logic                 VGA_VS_O,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = 3 * COLOR_W;

  typedef struct packed {
    logic [10:0]   x0;
    logic [10:0]   x1;
    logic [9:0]    y0;
    logic [9:0]    y1;
    logic [CW-1:0] color;
    logic          en;
`ifdef VGA_RECT_BORDER_EN
    logic          border;
`endif
  } slot_t;

  slot_t                shadow [NUM_RECTS];
  slot_t                active [NUM_RECTS];
  slot_t                wr_slot;
  logic [15:0]          acc;
  logic                 pix_stb;
  logic [10:0]          h;
  logic [9:0]           v;
  logic                 h_last, v_last, copy_pt, ready_q, pending, wr_fire;
  logic [NUM_RECTS-1:0] hit, hit_p1;
  logic                 act_p1, hs_p1, vs_p1;
  logic [CW-1:0]        pick, color_p2;

  assign h_last            = (h == 11'(H_TOTAL - 1));
  assign v_last            = (v == 10'(V_TOTAL - 1));
  assign copy_pt           = pix_stb && h_last && v_last;
  assign frame_start       = copy_pt;
  // Writes are refused on the copy cycle so a handshake can never race the shadow-to-active copy.
  assign wr.wr_ready       = ready_q && !copy_pt;
  assign wr.commit_pending = pending;
  assign wr_fire           = wr.wr_valid && wr.wr_ready;

  always_comb begin
    wr_slot       = '0;
    wr_slot.x0    = wr.wr_x0;
    wr_slot.x1    = wr.wr_x1;
    wr_slot.y0    = wr.wr_y0;
    wr_slot.y1    = wr.wr_y1;
    wr_slot.color = wr.wr_color;
    wr_slot.en    = wr.wr_en;
`ifdef VGA_RECT_BORDER_EN
    wr_slot.border = wr.wr_border;
`endif
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      acc     <= '0;
      pix_stb <= 1'b0;
      h       <= '0;
      v       <= '0;
      ready_q <= 1'b0;
    end else begin
      {pix_stb, acc} <= {1'b0, acc} + {1'b0, STB_INC};
      ready_q        <= 1'b1;
      if (pix_stb) begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? '0 : v + 10'd1;
        end else begin
          h <= h + 11'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      pending <= 1'b0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_RECTS; i++)
        if (wr_fire && wr.wr_idx == IDX_W'(i)) shadow[i] <= wr_slot;
      if (copy_pt) begin
        if (pending)
          for (int i = 0; i < NUM_RECTS; i++) active[i] <= shadow[i];
        pending <= wr.commit;
      end else if (wr.commit) begin
        pending <= 1'b1;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_RECTS; i++) begin
      hit[i] = active[i].en && (h >= active[i].x0) && (h < active[i].x1) &&
               (v >= active[i].y0) && (v < active[i].y1);
`ifdef VGA_RECT_BORDER_EN
      if (active[i].border)
        hit[i] = hit[i] && ((h == active[i].x0) || (h == active[i].x1 - 11'd1) ||
                            (v == active[i].y0) || (v == active[i].y1 - 10'd1));
`endif
    end
  end

  always_comb begin
    pick = '0;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (hit_p1[i]) pick = active[i].color;
  end

  always_ff @(posedge CLK or posedge RST_BTN) begin
    if (RST_BTN) begin
      hit_p1   <= '0;
      act_p1   <= 1'b0;
      hs_p1    <= 1'b0;
      vs_p1    <= 1'b0;
      color_p2 <= '0;
      VGA_HS_O <= 1'b0;
      VGA_VS_O <= 1'b0;
    end else if (pix_stb) begin
      // stage 1: hit vector, active-region flag, raw syncs
      hit_p1   <= hit;
      act_p1   <= (h < 11'(H_ACTIVE)) && (v < 10'(V_ACTIVE));
      hs_p1    <= (h >= 11'(H_ACTIVE + H_FP)) && (h < 11'(H_ACTIVE + H_FP + H_SYNC));
      vs_p1    <= (v >= 10'(V_ACTIVE + V_FP)) && (v < 10'(V_ACTIVE + V_FP + V_SYNC));
      // stage 2: resolved colour with syncs kept in step
      color_p2 <= act_p1 ? pick : '0;
      VGA_HS_O <= hs_p1;
      VGA_VS_O <= vs_p1;
    end
  end

  assign VGA_R = color_p2[CW-1 -: COLOR_W];
  assign VGA_G = color_p2[2*COLOR_W-1 -: COLOR_W];
  assign VGA_B = color_p2[COLOR_W-1:0];
endmodule

// File: tb/tb_vga_rect_compositor.sv
// Bench for vga_rect_compositor on a shrunken raster; per-cycle reference model plus probe tables.
`timescale 1ns/1ps
module tb_vga_rect_compositor;
  localparam int NUM = 3, CW = 4, IDXW = 2;
  localparam int HA = 40, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 30, VF = 1, VSY = 4, VB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FT = HT * VT;
  localparam longint INC = 64'h6666;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_start, hs, vs;
  logic [CW-1:0] r, g, b;

  vga_rect_compositor_if #(.IDX_W(IDXW), .COLOR_W(CW)) bus ();

  vga_rect_compositor #(
    .NUM_RECTS(NUM), .COLOR_W(CW), .STB_INC(16'h6666),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .IDX_W(IDXW)
  ) dut (
    .CLK(clk), .RST_BTN(rst), .wr(bus), .frame_start(frame_start),
    .VGA_HS_O(hs), .VGA_VS_O(vs), .VGA_R(r), .VGA_G(g), .VGA_B(b)
  );

  always #5 clk = ~clk;

  typedef struct { int x0; int x1; int y0; int y1; int color; bit en; bit border; } mslot_t;
  typedef struct { int x; int y; logic [11:0] rgb; } probe_t;

  mslot_t shadow [NUM];
  mslot_t active [NUM];
  bit     pend;
  int     m;
  int     checks = 0;
  int     errors = 0;
  bit     border_in = 1'b0;

`ifdef VGA_RECT_BORDER_EN
  assign bus.wr_border = border_in;
`endif

  // Strobes consumed by the counters after m clock edges since reset release.
  function automatic longint sval(int mm);
    if (mm <= 0) return 0;
    return ((longint'(mm) - 1) * INC) >> 16;
  endfunction

  function automatic bit copy_at(int mm);
    if (mm <= 0) return 1'b0;
    return (sval(mm + 1) != sval(mm)) && ((sval(mm) % FT) == FT - 1);
  endfunction

  function automatic int pick(int h, int v);
    for (int i = 0; i < NUM; i++)
      if (active[i].en && h >= active[i].x0 && h < active[i].x1 &&
          v >= active[i].y0 && v < active[i].y1 &&
          (!active[i].border || h == active[i].x0 || h == active[i].x1 - 1 ||
           v == active[i].y0 || v == active[i].y1 - 1))
        return active[i].color;
    return 0;
  endfunction

  function automatic logic [16:0] expect_now();
    longint s;
    int p, h, v, rgb;
    bit cp, rdy, ehs, evs;
    s = sval(m); cp = copy_at(m); rdy = (m >= 1) && !cp;
    ehs = 1'b0; evs = 1'b0; rgb = 0;
    if (s >= 2) begin
      p   = int'((s - 2) % FT);
      h   = p % HT;
      v   = p / HT;
      ehs = (h >= HA + HF) && (h < HA + HF + HSY);
      evs = (v >= VA + VF) && (v < VA + VF + VSY);
      if (h < HA && v < VA) rgb = pick(h, v);
    end
    return {cp, rdy, pend, ehs, evs, 12'(rgb)};
  endfunction

  function automatic logic [16:0] actual();
    return {frame_start, bus.wr_ready, bus.commit_pending, hs, vs, r, g, b};
  endfunction

  task automatic check(string name, logic [16:0] act, logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s m=%0d got %h expected %h", name, m, act, exp);
    end
  endtask

  task automatic tick();
    bit cp, rdy;
    mslot_t s;
    cp  = copy_at(m);
    rdy = (m >= 1) && !cp;
    if (bus.wr_valid && rdy && int'(bus.wr_idx) < NUM) begin
      s.x0 = int'(bus.wr_x0); s.x1 = int'(bus.wr_x1);
      s.y0 = int'(bus.wr_y0); s.y1 = int'(bus.wr_y1);
      s.color = int'(bus.wr_color); s.en = bus.wr_en; s.border = 1'b0;
`ifdef VGA_RECT_BORDER_EN
      s.border = border_in;
`endif
      shadow[bus.wr_idx] = s;
    end
    if (cp) begin
      if (pend) active = shadow;
      pend = bus.commit;
    end else if (bus.commit) begin
      pend = 1'b1;
    end
    @(posedge clk);
    m++;
    @(negedge clk);
    check("cycle", actual(), expect_now());
  endtask

  task automatic wait_at(int pos, int lag, output bit ok);
    longint s;
    ok = 1'b0;
    for (int n = 0; n < 3 * FT; n++) begin
      s = sval(m);
      if (s >= lag && ((s - lag) % FT) == pos) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_commit();
    for (int n = 0; n < 3 * FT && pend; n++) tick();
    check("commit_done", {16'h0, pend}, 17'h0);
  endtask

  task automatic write_slot(int idx, int x0, int x1, int y0, int y1, int col, bit en, bit brd);
    bit acc_now;
    bus.wr_idx = IDXW'(idx); bus.wr_x0 = 11'(x0); bus.wr_x1 = 11'(x1);
    bus.wr_y0 = 10'(y0); bus.wr_y1 = 10'(y1); bus.wr_color = 12'(col);
    bus.wr_en = en; border_in = brd; bus.wr_valid = 1'b1;
    for (int n = 0; n < 8; n++) begin
      acc_now = (m >= 1) && !copy_at(m);
      tick();
      if (acc_now) break;
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  task automatic run_probes(string name, probe_t tbl[$]);
    bit ok;
    foreach (tbl[i]) begin
      wait_at(tbl[i].y * HT + tbl[i].x, 2, ok);
      if (!ok) check({name, "_timeout"}, 17'h0, 17'h1);
      else     check(name, {5'h0, r, g, b}, {5'h0, tbl[i].rgb});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async", actual(), 17'h0);
    m = 0; pend = 1'b0;
    foreach (shadow[i]) begin
      shadow[i] = '{default: 0};
      active[i] = '{default: 0};
    end
    repeat (3) @(negedge clk);
    check("reset_hold", actual(), 17'h0);
    rst = 1'b0;
  endtask

  initial begin
    probe_t overlap[$];
    probe_t outline[$];
    bit ok;
    int fs_dut, fs_ref;

    overlap = '{
      '{5, 2, 12'hF00}, '{25, 2, 12'h000}, '{15, 10, 12'hF00}, '{20, 10, 12'h0F0},
      '{25, 10, 12'h0F0}, '{29, 19, 12'h0F0}, '{30, 19, 12'h000}, '{29, 20, 12'h000},
      '{35, 25, 12'h000}};
    outline = '{
      '{10, 10, 12'hFFF}, '{15, 10, 12'hFFF}, '{10, 15, 12'hFFF}, '{15, 15, 12'h000},
      '{19, 15, 12'hFFF}, '{20, 15, 12'h000}, '{11, 18, 12'h000}, '{15, 19, 12'hFFF}};

    bus.wr_valid = 1'b0; bus.wr_idx = '0; bus.wr_x0 = '0; bus.wr_x1 = '0;
    bus.wr_y0 = '0; bus.wr_y1 = '0; bus.wr_color = '0; bus.wr_en = 1'b0;
    bus.commit = 1'b0; m = 0; pend = 1'b0;
    do_reset();

    // blank frame: syncs, strobe cadence, frame_start
    fs_dut = 0; fs_ref = 0;
    for (int n = 0; n < FT * 5 / 2 + 200; n++) begin
      tick();
      fs_dut += int'(frame_start);
      fs_ref += int'(copy_at(m));
    end
    check("frame_pulses", 17'(fs_dut), 17'(fs_ref));

    // overlap and degenerate slot, written and committed mid-frame
    wait_at(15 * HT, 0, ok);
    if (!ok) check("mid_frame_timeout", 17'h0, 17'h1);
    write_slot(0, 0, 20, 0, 15, 12'hF00, 1'b1, 1'b0);
    write_slot(1, 10, 30, 5, 20, 12'h0F0, 1'b1, 1'b0);
    write_slot(2, 25, 25, 0, 30, 12'h00F, 1'b1, 1'b0);
    do_commit();
    check("pending_set", {16'h0, bus.commit_pending}, 17'h1);
    wait_commit();
    run_probes("overlap", overlap);

    // write held across the copy point is taken one clock later
    for (int n = 0; n < 3 * FT && !copy_at(m); n++) tick();
    check("at_copy_point", {16'h0, frame_start}, 17'h1);
    bus.wr_idx = 2'd1; bus.wr_x0 = 11'd0; bus.wr_x1 = 11'd40; bus.wr_y0 = 10'd25;
    bus.wr_y1 = 10'd30; bus.wr_color = 12'h00F; bus.wr_en = 1'b1; border_in = 1'b0;
    bus.wr_valid = 1'b1;
    check("ready_on_copy", {16'h0, bus.wr_ready}, 17'h0);
    tick();
    check("ready_after_copy", {16'h0, bus.wr_ready}, 17'h1);
    tick();
    bus.wr_valid = 1'b0;
    do_commit();
    wait_commit();
    run_probes("held_write", '{'{5, 5, 12'hF00}, '{20, 10, 12'h000}, '{20, 27, 12'h00F}});

    // randomized writes and commits against the model
    for (int n = 0; n < 8000; n++) begin
      bus.wr_valid = ($urandom % 4) == 0;
      bus.wr_idx = IDXW'($urandom % 4);
      bus.wr_x0 = 11'($urandom % 64); bus.wr_x1 = 11'($urandom % 64);
      bus.wr_y0 = 10'($urandom % 48); bus.wr_y1 = 10'($urandom % 48);
      bus.wr_color = 12'($urandom); bus.wr_en = ($urandom % 4) != 0;
      border_in = $urandom % 2;
      bus.commit = ($urandom % 300) == 0;
      tick();
    end
    bus.wr_valid = 1'b0;
    bus.commit = 1'b0;
    do_commit();
    for (int n = 0; n < FT * 5 / 2 + 100; n++) tick();

`ifdef VGA_RECT_BORDER_EN
    write_slot(0, 10, 20, 10, 20, 12'hFFF, 1'b1, 1'b1);
    write_slot(1, 0, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    write_slot(2, 0, 0, 0, 0, 12'h000, 1'b0, 1'b0);
    do_commit();
    wait_commit();
    run_probes("outline", outline);
`endif

    // asynchronous reset in the middle of a frame
    wait_at(20 * HT + 10, 0, ok);
    if (!ok) check("reset_point_timeout", 17'h0, 17'h1);
    do_reset();
    for (int n = 0; n < FT * 5 / 2 + 100; n++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
